fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder stage that sits directly downstream of the radix-2^2 SDF FFT core.
- The core emits each N-point frame in bit-reversed index order, one sample per valid cycle. This block buffers frames in a ping-pong RAM and replays them in natural order (bin 0 to bin N-1) to the next consumer.
- It runs in the same clock domain as the FFT core and has no backpressure.

Parameters:
- DATA_WIDTH, 16, width of each real and imaginary sample.
- N_POINTS, 16, frame length. Must be a power of 2 and at least 4.
- LOG2N_BITS, $clog2(N_POINTS), derived index width. Do not override.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- in_val  input  1  input sample valid, driven from the FFT b_val.
- in_re  input  DATA_WIDTH  input real part, bit-reversed frame order.
- in_im  input  DATA_WIDTH  input imaginary part.
- out_val  output  1  output sample valid.
- out_re  output  DATA_WIDTH  output real part, natural order.
- out_im  output  DATA_WIDTH  output imaginary part.
- out_idx  output  LOG2N_BITS  frequency bin index of the current output sample.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: out_val=0, out_re=0, out_im=0, out_idx=0, wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0. RAM contents are not reset.
- Storage: 2 banks x N_POINTS entries x 2*DATA_WIDTH bits. Must infer as simple dual-port RAM (one write port, one read port).
- Write side: on each clk edge with in_val=1, store {in_re,in_im} at bank wr_bank, address bitrev(wr_cnt) over LOG2N_BITS, then increment wr_cnt.
- Frame complete: when wr_cnt=N-1 and in_val=1, wr_cnt wraps to 0, wr_bank toggles, and a start pulse for the just-filled bank is raised that same edge.
- Gaps: in_val may deassert anywhere mid-frame. wr_cnt holds and the frame position is preserved.
- Read FSM has two states:
  - IDLE to RUN on the start pulse. Latch rd_bank = the filled bank, set rd_cnt=0.
  - RUN: read address rd_cnt in rd_bank every cycle, increment rd_cnt. Return to IDLE after rd_cnt=N-1 is issued.
  - RUN to RUN: if a new start pulse coincides with the final read cycle, rd_bank switches and rd_cnt restarts at 0 with no bubble.
- Output timing:
  - RAM read is registered. out_val, out_re, out_im and out_idx (= rd_cnt delayed) update one cycle after the address is issued.
  - Latency: sample N-1 of a frame is accepted at edge k. out_val is first high after edge k+2 (bin 0) and stays high for exactly N consecutive cycles.
- When out_val=0: out_re, out_im and out_idx hold their last values.
- Rate guarantee: the input carries at most one sample per cycle, so the next frame completes no earlier than the read of the previous frame ends. Full-rate input therefore produces a contiguous out_val stream.
- A start pulse while RUN with rd_cnt != N-1 is a protocol violation. The new bank is queued (one-deep pending flag) and read immediately after the current frame.
- Reset mid-operation: any partial frame and any pending or active readout is discarded. The first in_val after rst deasserts is treated as bin-reversed index 0 of a new frame.

Optional Feature:
- Macro: FFT_REORDER_FRAME_FLAGS_EN.
- Defined: add outputs out_sof and out_eof, 1 bit each, reset to 0. They are registered alongside out_val:
  - out_sof=1 with the out_idx=0 sample.
  - out_eof=1 with the out_idx=N-1 sample.
  - both are 0 whenever out_val=0.
- Undefined: these ports do not exist. All other behaviour is identical.

Test Plan:
- Single frame, N=16. Input in_re=bitrev4(i)*4 and in_im=-in_re for i=0..15, in_val continuous. Expect 16 cycles of out_val beginning 2 edges after the last input, with out_re=0,4,8,...,60, out_im negated, and out_idx=0..15.
- Back-to-back: 4 frames at full rate with distinct ramps (frame f adds f*256). Expect 64 contiguous out_val cycles, correct per-frame values, and no gap between frames.
- Gapped input: in_val toggles 1,0,0,1 across a frame. Expect the output identical to the single-frame case, starting 2 edges after the 16th accepted sample.
- Reset mid-frame: drop rst after 7 samples, release, then send a full frame. Expect no output for the aborted frame and a correct output for the new frame.
- Reset during readout: assert rst when out_idx=5. Expect out_val=0 and all outputs 0 immediately (asynchronous), and no resumption after release.
- Flags build with FFT_REORDER_FRAME_FLAGS_EN: 2 full-rate frames. Expect out_sof high exactly at out_idx=0 and out_eof exactly at out_idx=15, 2 pulses each.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that replays bit-reversed FFT frames in natural bin order.
// Define FFT_REORDER_FRAME_FLAGS_EN to add the out_sof/out_eof frame marker outputs.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 16,
    parameter int LOG2N_BITS = $clog2(N_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_val,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
`ifdef FFT_REORDER_FRAME_FLAGS_EN
    output logic                  out_sof,
    output logic                  out_eof,
`endif
    output logic [LOG2N_BITS-1:0] out_idx
);
    localparam logic [LOG2N_BITS-1:0] LAST = LOG2N_BITS'(N_POINTS - 1);
    localparam logic [LOG2N_BITS-1:0] ONE  = LOG2N_BITS'(1);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [LOG2N_BITS-1:0] bitrev(input logic [LOG2N_BITS-1:0] a);
        for (int i = 0; i < LOG2N_BITS; i++) bitrev[i] = a[LOG2N_BITS-1-i];
    endfunction

    logic [2*DATA_WIDTH-1:0] mem [2*N_POINTS];

    logic [LOG2N_BITS-1:0] wr_cnt_q, wr_cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  start_q, start_d;
    logic                  start_bank_q, start_bank_d;
    state_t                state_q, state_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [LOG2N_BITS-1:0] rd_cnt_q, rd_cnt_d;
    logic                  pend_q, pend_d;
    logic                  pend_bank_q, pend_bank_d;
    logic                  out_val_q, out_val_d;
    logic [DATA_WIDTH-1:0] out_re_q, out_re_d;
    logic [DATA_WIDTH-1:0] out_im_q, out_im_d;
    logic [LOG2N_BITS-1:0] out_idx_q, out_idx_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic [LOG2N_BITS:0]   wr_addr, rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_word;
    logic                  frame_done;

    assign wr_addr    = {wr_bank_q, bitrev(wr_cnt_q)};
    assign rd_addr    = {rd_bank_q, rd_cnt_q};
    assign rd_word    = mem[rd_addr];
    assign frame_done = in_val && (wr_cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (in_val) mem[wr_addr] <= {in_re, in_im};
    end

    always_comb begin
        wr_cnt_d     = in_val ? wr_cnt_q + ONE : wr_cnt_q;
        wr_bank_d    = frame_done ? ~wr_bank_q : wr_bank_q;
        start_d      = frame_done;
        start_bank_d = frame_done ? wr_bank_q : start_bank_q;
    end

    // A start arriving mid-readout is parked in the one-deep pending slot and served first.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        if (state_q == IDLE) begin
            if (start_q) begin
                state_d   = RUN;
                rd_bank_d = start_bank_q;
                rd_cnt_d  = '0;
            end
        end else begin
            rd_cnt_d = rd_cnt_q + ONE;
            if (rd_cnt_q == LAST) begin
                if (pend_q) begin
                    rd_bank_d   = pend_bank_q;
                    pend_d      = start_q;
                    pend_bank_d = start_q ? start_bank_q : pend_bank_q;
                end else if (start_q) begin
                    rd_bank_d = start_bank_q;
                end else begin
                    state_d = IDLE;
                end
            end else if (start_q) begin
                pend_d      = 1'b1;
                pend_bank_d = start_bank_q;
            end
        end
    end

    always_comb begin
        out_val_d = (state_q == RUN);
        out_re_d  = out_val_d ? rd_word[2*DATA_WIDTH-1 -: DATA_WIDTH] : out_re_q;
        out_im_d  = out_val_d ? rd_word[DATA_WIDTH-1:0] : out_im_q;
        out_idx_d = out_val_d ? rd_cnt_q : out_idx_q;
        out_sof_d = out_val_d && (rd_cnt_q == '0);
        out_eof_d = out_val_d && (rd_cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            start_q      <= 1'b0;
            start_bank_q <= 1'b0;
            state_q      <= IDLE;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            pend_q       <= 1'b0;
            pend_bank_q  <= 1'b0;
            out_val_q    <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_idx_q    <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            start_q      <= start_d;
            start_bank_q <= start_bank_d;
            state_q      <= state_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            pend_q       <= pend_d;
            pend_bank_q  <= pend_bank_d;
            out_val_q    <= out_val_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
            out_idx_q    <= out_idx_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
        end
    end

    assign out_val = out_val_q;
    assign out_re  = out_re_q;
    assign out_im  = out_im_q;
    assign out_idx = out_idx_q;
`ifdef FFT_REORDER_FRAME_FLAGS_EN
    assign out_sof = out_sof_q;
    assign out_eof = out_eof_q;
`else
    logic unused_flags;
    assign unused_flags = out_sof_q ^ out_eof_q;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: table-driven single frame plus scoreboarded random/gapped/reset sequences.
module tb_fft_bitrev_reorder;
    localparam int DW = 16;
    localparam int N  = 16;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_val = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_val;
    logic [DW-1:0] out_re, out_im;
    logic [L-1:0]  out_idx;
`ifdef FFT_REORDER_FRAME_FLAGS_EN
    logic out_sof, out_eof;
    int   sof_n = 0, eof_n = 0, frames_out = 0;
`endif

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    typedef struct {int cyc; logic [DW-1:0] re; logic [DW-1:0] im; logic [L-1:0] idx;} exp_t;
    typedef struct {logic [DW-1:0] re; logic [DW-1:0] im; logic [DW-1:0] exp_re; logic [DW-1:0] exp_im; logic [L-1:0] exp_idx;} vec_t;

    exp_t          exp_q[$];
    logic [2*DW-1:0] fbuf [N];
    int            wpos = 0;
    int            last_cyc = 0;

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_re(in_re), .in_im(in_im),
        .out_val(out_val), .out_re(out_re), .out_im(out_im),
`ifdef FFT_REORDER_FRAME_FLAGS_EN
        .out_sof(out_sof), .out_eof(out_eof),
`endif
        .out_idx(out_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int br(input int x);
        int r = 0;
        for (int k = 0; k < L; k++) r |= ((x >> k) & 1) << (L - 1 - k);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: natural bin b of a frame is the sample that arrived at position bitrev(b).
    task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int st;
        exp_t e;
        fbuf[wpos] = {re, im};
        wpos++;
        if (wpos == N) begin
            st = cyc + 2;
            if (st <= last_cyc) st = last_cyc + 1;
            for (int b = 0; b < N; b++) begin
                e.cyc = st + b;
                e.re  = fbuf[br(b)][2*DW-1:DW];
                e.im  = fbuf[br(b)][DW-1:0];
                e.idx = L'(b);
                exp_q.push_back(e);
            end
            last_cyc = st + N - 1;
            wpos = 0;
        end
    endtask

    task automatic model_reset();
        wpos = 0;
        last_cyc = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        in_val = v;
        in_re  = re;
        in_im  = im;
        @(posedge clk);
        #1;
        if (v) model_accept(re, im);
        in_val = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en && rst) begin
            if (out_val) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out_val", 32'(out_val), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cycle", cyc, e.cyc);
                    check("sb_re", 32'(out_re), 32'(e.re));
                    check("sb_im", 32'(out_im), 32'(e.im));
                    check("sb_idx", 32'(out_idx), 32'(e.idx));
`ifdef FFT_REORDER_FRAME_FLAGS_EN
                    check("sb_sof", 32'(out_sof), 32'(e.idx == 0));
                    check("sb_eof", 32'(out_eof), 32'(e.idx == L'(N - 1)));
                    if (out_sof) sof_n++;
                    if (out_eof) eof_n++;
                    if (e.idx == 0) frames_out++;
`endif
                end
            end
`ifdef FFT_REORDER_FRAME_FLAGS_EN
            else begin
                check("sof_idle", 32'(out_sof), 0);
                check("eof_idle", 32'(out_eof), 0);
            end
`endif
        end
    end

    initial begin
        vec_t tbl [N];
        int   acc, quiet, found;
        logic [DW-1:0] r;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < N; i++) begin
            tbl[i].re      = DW'(br(i) * 4);
            tbl[i].im      = DW'(-(br(i) * 4));
            tbl[i].exp_re  = DW'(i * 4);
            tbl[i].exp_im  = DW'(-(i * 4));
            tbl[i].exp_idx = L'(i);
        end

        #12;
        check("rst_out_val", 32'(out_val), 0);
        check("rst_out_re", 32'(out_re), 0);
        check("rst_out_im", 32'(out_im), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) drive(1'b1, tbl[i].re, tbl[i].im);
        @(posedge clk);
        #1;
        check("tbl_lat_k1_quiet", 32'(out_val), 0);
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            check("tbl_val", 32'(out_val), 1);
            check("tbl_re", 32'(out_re), 32'(tbl[i].exp_re));
            check("tbl_im", 32'(out_im), 32'(tbl[i].exp_im));
            check("tbl_idx", 32'(out_idx), 32'(tbl[i].exp_idx));
        end
        @(posedge clk);
        #1;
        check("tbl_end_val", 32'(out_val), 0);
        check("tbl_hold_re", 32'(out_re), 32'(tbl[N-1].exp_re));
        check("tbl_hold_idx", 32'(out_idx), 32'(tbl[N-1].exp_idx));
        exp_q.delete();
        chk_en = 1'b1;

        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N; i++) begin
                r = DW'(br(i) * 4 + f * 256);
                drive(1'b1, r, -r);
            end
        drain();

        acc = 0;
        for (int c = 0; acc < N; c++) begin
            drive(pat[c % 4], tbl[acc].re, tbl[acc].im);
            if (pat[c % 4]) acc++;
        end
        drain();

        for (int f = 0; f < 5; f++) begin
            acc = 0;
            while (acc < N) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive(1'b1, DW'($urandom), DW'($urandom));
                    acc++;
                end else begin
                    drive(1'b0, DW'($urandom), DW'($urandom));
                end
            end
        end
        drain();

        for (int i = 0; i < 7; i++) drive(1'b1, DW'(1000 + i), DW'(2000 + i));
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_mid_frame_val", 32'(out_val), 0);
        rst = 1'b1;
        for (int i = 0; i < N; i++) drive(1'b1, DW'($urandom), DW'($urandom));
        drain();

        for (int i = 0; i < N; i++) drive(1'b1, tbl[i].re, tbl[i].im);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_val && out_idx == 5) found = 1;
        end
        check("readout_idx5_reached", found, 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_val", 32'(out_val), 0);
        check("async_rst_re", 32'(out_re), 0);
        check("async_rst_im", 32'(out_im), 0);
        check("async_rst_idx", 32'(out_idx), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_val) quiet++;
        end
        check("no_resume_after_rst", quiet, 0);

`ifdef FFT_REORDER_FRAME_FLAGS_EN
        check("sof_pulses", sof_n, frames_out);
        check("eof_pulses", eof_n, frames_out);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
